gate_tt_checker: RTL and testbench

GATE_TT_CHECKER -- requirements
Module: gate_tt_checker

---
 rtl/gate_tt_checker.sv | 155 +++++++++++++++
 tb/tb_gate_tt_checker.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gate_tt_checker.sv
// Truth-table checker for a two-input gate under test.
// On start, the four {A,B} vectors are applied in order 00, 01, 10, 11.
// Each vector is held for SETTLE cycles, and then F is captured into observed[{A,B}].
// When the sweep ends, the captured table is compared against the expected table
// for the latched gate code. The checker also reports which known gate the table matches.
module gate_tt_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] gate_sel,
    output logic       drv_a,
    output logic       drv_b,
    input  logic       dut_f,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] observed,
    output logic [2:0] gate_id
);

    localparam int unsigned CNT_W    = 8;
    localparam int unsigned IDX_W    = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(3);
    localparam logic [2:0]       ID_NONE  = 3'd7;
    localparam logic [2:0]       SEL_MAX  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_sel;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_drv;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [3:0]       r_observed;
    logic [2:0]       r_gate_id;

    logic [3:0]       w_table;
    logic             w_sample;

    // Expected truth table for a gate code, indexed by {A,B}. Reserved codes map to 0000.
    function automatic logic [3:0] exp_table(input logic [2:0] code);
        logic [3:0] t;
        case (code)
            3'd0:    t = 4'b1000;
            3'd1:    t = 4'b1110;
            3'd2:    t = 4'b0111;
            3'd3:    t = 4'b0001;
            3'd4:    t = 4'b0110;
            3'd5:    t = 4'b1001;
            default: t = 4'b0000;
        endcase
        return t;
    endfunction

    // Reverse lookup: the unique gate code whose table equals t, or 7 when none matches.
    function automatic logic [2:0] id_of(input logic [3:0] t);
        logic [2:0] id;
        case (t)
            4'b1000: id = 3'd0;
            4'b1110: id = 3'd1;
            4'b0111: id = 3'd2;
            4'b0001: id = 3'd3;
            4'b0110: id = 3'd4;
            4'b1001: id = 3'd5;
            default: id = ID_NONE;
        endcase
        return id;
    endfunction

    // Table as it will stand once the current sample lands; the final verdict uses it.
    always_comb begin
        w_table        = r_observed;
        w_table[r_idx] = dut_f;
    end

    assign w_sample = (r_cnt == CNT_LAST);

    // Sweep sequencer: the state, stimulus, capture, and verdict registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sel      <= 3'd0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_drv      <= 2'b00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_observed <= 4'b0000;
            r_gate_id  <= ID_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sel      <= gate_sel;
                        r_idx      <= '0;
                        r_cnt      <= '0;
                        r_drv      <= 2'b00;
                        r_observed <= 4'b0000;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    if (w_sample) begin
                        r_observed <= w_table;
                        r_cnt      <= '0;
                        if (r_idx == IDX_LAST) begin
                            r_state   <= DONE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_drv     <= 2'b00;
                            r_pass    <= (r_sel <= SEL_MAX) && (w_table == exp_table(r_sel));
                            r_gate_id <= id_of(w_table);
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                            r_drv <= r_idx + IDX_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_drv   <= 2'b00;
                end
            endcase
        end
    end

    assign drv_a    = r_drv[1];
    assign drv_b    = r_drv[0];
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign observed = r_observed;
    assign gate_id  = r_gate_id;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker. A behavioural gate model drives dut_f.
// The expected tables and verdicts are derived from plain boolean evaluation.
module tb_gate_tt_checker;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] gate_sel;
    logic       drv_a;
    logic       drv_b;
    logic       dut_f;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] observed;
    logic [2:0] gate_id;

    int tb_gate = 8;   // 0..5 real gates, anything else = output tied low
    int total   = 0;
    int bad     = 0;

    gate_tt_checker #(.SETTLE(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .gate_sel (gate_sel),
        .drv_a    (drv_a),
        .drv_b    (drv_b),
        .dut_f    (dut_f),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .observed (observed),
        .gate_id  (gate_id)
    );

    always #5 clk = ~clk;

    function automatic logic gate_out(input int g, input logic a, input logic b);
        case (g)
            0:       return a & b;
            1:       return a | b;
            2:       return ~(a & b);
            3:       return ~(a | b);
            4:       return a ^ b;
            5:       return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    always_comb dut_f = gate_out(tb_gate, drv_a, drv_b);

    function automatic logic [3:0] ref_table(input int g);
        logic [3:0] t;
        for (int v = 0; v < 4; v++) t[v] = gate_out(g, v[1], v[0]);
        return t;
    endfunction

    function automatic logic [2:0] ref_id(input logic [3:0] t);
        int id = 7;
        for (int g = 0; g < 6; g++) if (ref_table(g) == t) id = g;
        return 3'(id);
    endfunction

    function automatic logic ref_pass(input logic [2:0] sel, input logic [3:0] t);
        return (sel < 3'd6) && (ref_table(int'(sel)) == t);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one full sweep from IDLE and checks it cycle by cycle.
    task automatic sweep(input int g, input logic [2:0] sel);
        logic [3:0] t;
        t        = ref_table(g);
        tb_gate  = g;
        gate_sel = sel;
        start    = 1'b1;
        tick();                       // edge 0
        start    = 1'b0;
        for (int k = 0; k < 4 * S; k++) begin
            if (k > 0) tick();
            chk("drv", {drv_a, drv_b}, k / S);
            chk("busy_run", busy, 1);
            chk("done_early", done, 0);
        end
        tick();                       // edge 4*S
        chk("done", done, 1);
        chk("busy_done", busy, 0);
        chk("drv_done", {drv_a, drv_b}, 0);
        chk("observed", observed, t);
        chk("pass", pass, ref_pass(sel, t));
        chk("gate_id", gate_id, ref_id(t));
        tick();
        chk("done_clear", done, 0);
    endtask

    initial begin
        int dones;
        int g;
        logic [2:0] sel;

        rst = 1'b1; start = 1'b0; gate_sel = 3'd0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_drv", {drv_a, drv_b}, 0);
        chk("rst_observed", observed, 0);
        chk("rst_gate_id", gate_id, 7);
        rst = 1'b0;
        tick();

        // Directed cases: NAND pass, XOR vs NAND, tied low, and NOR with a reserved code
        sweep(2, 3'd2);
        sweep(4, 3'd2);
        sweep(8, 3'd0);
        sweep(3, 3'd6);

        // Results hold in IDLE
        tick(); tick(); tick();
        chk("hold_observed", observed, 4'b0001);
        chk("hold_gate_id", gate_id, 3);
        chk("hold_pass", pass, 0);

        // Extra starts and a gate_sel change during the sweep are ignored
        tb_gate = 0; gate_sel = 3'd0; start = 1'b1;
        tick();                       // edge 0
        start = 1'b0;
        dones = 0;
        for (int k = 1; k <= 12; k++) begin
            start = (k == 3 || k == 8);
            if (k == 2) gate_sel = 3'd4;
            tick();
            start = 1'b0;
            if (done === 1'b1) dones++;
            if (k == 8) chk("ign_done_at8", done, 1);
        end
        chk("ign_done_count", dones, 1);
        chk("ign_pass", pass, 1);
        chk("ign_observed", observed, 4'b1000);

        // Reset mid-sweep abandons the sweep
        tb_gate = 2; gate_sel = 3'd2; start = 1'b1;
        tick();                       // edge 0
        start = 1'b0;
        tick(); tick(); tick(); tick();   // edges 1..4
        rst = 1'b1;
        tick();                       // edge 5
        rst = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_observed", observed, 0);
        chk("mrst_gate_id", gate_id, 7);
        chk("mrst_drv", {drv_a, drv_b}, 0);
        chk("mrst_done", done, 0);
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        chk("mrst_no_done", dones, 0);
        sweep(2, 3'd2);

        // Randomised sweeps against the model
        for (int i = 0; i < 16; i++) begin
            g = int'($urandom_range(0, 6));
            if (g == 6) g = 8;
            if (g < 6 && $urandom_range(0, 1) == 1) sel = 3'(g);
            else sel = 3'($urandom_range(0, 7));
            sweep(g, sel);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
